pe_dot_seq: RTL and testbench
=============================

Name: pe_dot_seq

Overview:
- Sequencer that drives one FP32 multiply-accumulate PE (single-outstanding, in_valid/out_valid, chained psum) through a K-term dot product for the attention-score datapath.
- Accepts a job (length, initial psum) and a streamed operand pair per term. It issues one PE op per term and feeds each PE result back as the next psum.
- Returns the final FP32 sum on a valid/ready result port. Includes PE watchdog and abort-with-drain.

Parameters:
- K_MAX, 64, maximum terms per job.
- LEN_W, $clog2(K_MAX+1), width of job length and term counter.
- TIMEOUT, 256, cycles allowed in WAIT before flagging a PE hang (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  term count; values above K_MAX are clamped to K_MAX.
- init_psum  in  32  FP32 accumulator seed.
- abort  in  1  synchronous cancel of current job.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after result handshake.
- err  out  1  sticky watchdog flag; cleared on the next accepted start.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  combinational, equal to (state==FETCH).
- op_a, op_b  in  32  FP32 operands.
- pe_in_valid  out  1  registered one-cycle issue pulse to the PE.
- pe_a, pe_b, pe_psum  out  32  registered PE operands.
- pe_out_valid  in  1  PE result strobe.
- pe_psum_out  in  32  PE result.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  32  final FP32 sum.

Behaviour:
- Reset, asynchronous: state=IDLE; acc=0, cnt=0, len_r=0, wdog=0. Outputs busy, done, err, pe_in_valid, res_valid are 0. pe_a, pe_b, pe_psum, res_data are 32'h0.
- States: IDLE, FETCH, WAIT, RESULT, DRAIN.
- IDLE:
  - start with len!=0: latch len_r, set acc=init_psum, cnt=0, err=0, go to FETCH.
  - start with len==0: set acc=init_psum, err=0, go to RESULT. No PE issue occurs.
  - pe_out_valid is ignored.
- FETCH:
  - On op_valid&&op_ready: next cycle pe_a=op_a, pe_b=op_b, pe_psum=acc, and pe_in_valid=1 for exactly one cycle. Then wdog=0 and go to WAIT.
  - Without a handshake, stay in FETCH.
- WAIT:
  - wdog increments each cycle.
  - On pe_out_valid: acc=pe_psum_out, cnt=cnt+1. Go to RESULT if cnt+1==len_r, else go to FETCH.
  - If wdog==TIMEOUT-1 with no pe_out_valid: err=1, go to RESULT with the current acc (partial sum).
  - pe_out_valid on the same cycle as the timeout takes priority; no error is raised.
- RESULT:
  - res_valid=1 and res_data=acc, held stable until res_ready.
  - On the handshake: res_valid drops next cycle, done=1 for that one cycle, state=IDLE.
  - A start arriving on the done cycle is accepted.
- Abort, any busy state, evaluated with priority over all other transitions:
  - From FETCH or RESULT: go to IDLE next cycle, res_valid=0, no done pulse.
  - From WAIT: go to DRAIN.
  - Also on the issue cycle: a pe_in_valid pulse already registered is allowed to complete, and the state goes to DRAIN.
- DRAIN:
  - Wait for pe_out_valid, or for the watchdog to expire (err=1), then go to IDLE.
  - The result is discarded and acc is unchanged.
  - This guarantees the PE is idle before the next job is issued.
- Latency per term: 1 cycle FETCH→issue, plus PE latency, plus 1 cycle back to FETCH.
- Total job latency: len×(PE_lat+2)+1 cycles to res_valid, assuming op_valid is held high.
- No FP arithmetic is performed here. acc is a pure 32-bit register; NaN and Inf pass through untouched.
- At most one PE op is outstanding at any time. pe_in_valid is never asserted outside the cycle after a FETCH handshake.

Test Plan:
- len=2, init_psum=32'h00000000, pairs (3F800000,40400000), (40000000,40800000), behavioural PE latency 7 → two pe_in_valid pulses; second pe_psum=40400000; res_data=41300000 (11.0); done one cycle after res_ready.
- len=0, init_psum=3F800000 → no pe_in_valid; res_valid next cycle with res_data=3F800000; op_ready never high.
- TIMEOUT=16, PE model never asserts out_valid, len=3 → err=1 exactly 16 cycles after entering WAIT; res_data=init_psum; a new start clears err.
- len=1 with res_ready held low 5 cycles → res_valid/res_data stable throughout; done pulses once after acceptance; an extra start while busy is ignored.
- Abort during WAIT (PE latency 7) → busy stays high in DRAIN until pe_out_valid, then IDLE; no res_valid and no done; the next job produces correct sums.
- rst driven low asynchronously mid-FETCH and mid-WAIT → all outputs 0 immediately; after release, busy=0 and an op_valid stream produces no op_ready until start.

Source files
------------

// File: rtl/pe_dot_seq.sv
// Drives one chained-psum FP32 MAC PE through a K-term dot product, one op in flight at a time.
// The result is returned on a valid/ready port. A watchdog guards against a hung PE, and abort drains any op already issued.
module pe_dot_seq #(
  parameter int K_MAX   = 64,
  parameter int LEN_W   = $clog2(K_MAX + 1),
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      init_psum,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             pe_in_valid,
  output logic [31:0]      pe_a,
  output logic [31:0]      pe_b,
  output logic [31:0]      pe_psum,
  input  logic             pe_out_valid,
  input  logic [31:0]      pe_psum_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);
  localparam int               WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(K_MAX);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_RESULT, S_DRAIN} state_t;

  state_t           state, state_next;
  logic [31:0]      acc, acc_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic [LEN_W-1:0] len_r, len_r_next;
  logic [WD_W-1:0]  wdog, wdog_next;
  logic             err_next, done_next, pe_in_valid_next;
  logic [31:0]      pe_a_next, pe_b_next, pe_psum_next;
  logic [LEN_W-1:0] len_clamped, cnt_inc;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign cnt_inc     = cnt + 1'b1;
  assign busy        = (state != S_IDLE);
  assign op_ready    = (state == S_FETCH);
  assign res_valid   = (state == S_RESULT);
  assign res_data    = res_valid ? acc : '0;

  always_comb begin
    // NOTE: every next-value is defaulted before the case so no path can infer a latch.
    state_next       = state;
    acc_next         = acc;
    cnt_next         = cnt;
    len_r_next       = len_r;
    wdog_next        = wdog;
    err_next         = err;
    done_next        = 1'b0;
    pe_in_valid_next = 1'b0;
    pe_a_next        = pe_a;
    pe_b_next        = pe_b;
    pe_psum_next     = pe_psum;

    case (state)
      S_IDLE: begin
        if (start) begin
          acc_next = init_psum;
          err_next = 1'b0;
          if (len == '0) begin
            state_next = S_RESULT;
          end else begin
            len_r_next = len_clamped;
            cnt_next   = '0;
            state_next = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (op_valid) begin
          pe_a_next        = op_a;
          pe_b_next        = op_b;
          pe_psum_next     = acc;
          pe_in_valid_next = 1'b1;
          wdog_next        = '0;
          state_next       = S_WAIT;
        end
      end
      S_WAIT: begin
        wdog_next = wdog + 1'b1;
        if (abort) begin
          // A result landing with the abort means the PE is already idle; nothing left to drain.
          state_next = pe_out_valid ? S_IDLE : S_DRAIN;
        end else if (pe_out_valid) begin
          acc_next   = pe_psum_out;
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == len_r) ? S_RESULT : S_FETCH;
        end else if (wdog == WD_LAST) begin
          err_next   = 1'b1;
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (res_ready) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        wdog_next = wdog + 1'b1;
        if (pe_out_valid) begin
          state_next = S_IDLE;
        end else if (wdog == WD_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so each one samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      len_r       <= '0;
      wdog        <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      pe_in_valid <= 1'b0;
      pe_a        <= '0;
      pe_b        <= '0;
      pe_psum     <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      len_r       <= len_r_next;
      wdog        <= wdog_next;
      err         <= err_next;
      done        <= done_next;
      pe_in_valid <= pe_in_valid_next;
      pe_a        <= pe_a_next;
      pe_b        <= pe_b_next;
      pe_psum     <= pe_psum_next;
    end
  end

endmodule

// File: tb/tb_pe_dot_seq.sv
// Self-checking bench for pe_dot_seq. It uses a behavioural FP32 MAC PE with programmable latency.
// Expected sums are computed as integer dot products and converted to FP32.
module tb_pe_dot_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, op_valid, res_ready;
  logic [6:0]  len;
  logic [31:0] init_psum, op_a, op_b;
  logic        busy, done, err, op_ready, pe_in_valid, res_valid;
  logic [31:0] pe_a, pe_b, pe_psum, res_data;
  logic        pe_out_valid;
  logic [31:0] pe_psum_out;

  int n_vec = 0;
  int n_bad = 0;

  // PE model controls and observations
  int          pe_lat = 1;
  bit          pe_hang = 1'b0;
  bit          pe_pending;
  int          pe_left;
  logic [31:0] pe_res;
  bit          overlap = 1'b0;
  logic [31:0] last_psum = '0;
  int          issue_cnt = 0;

  int unsigned opa_tab[64];
  int unsigned opb_tab[64];

  always #5 clk = ~clk;

  pe_dot_seq #(.K_MAX(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .init_psum(init_psum), .abort(abort),
    .busy(busy), .done(done), .err(err), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .pe_in_valid(pe_in_valid), .pe_a(pe_a), .pe_b(pe_b),
    .pe_psum(pe_psum), .pe_out_valid(pe_out_valid), .pe_psum_out(pe_psum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], 11'(e), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    m = v << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] pe_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    return real_to_fp(fp_to_real(s) + fp_to_real(a) * fp_to_real(b));
  endfunction

  // Behavioural PE: result appears pe_lat cycles after the issue cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_out_valid <= 1'b0;
      pe_psum_out  <= '0;
      pe_pending   <= 1'b0;
      pe_left      <= 0;
    end else begin
      pe_out_valid <= 1'b0;
      if (pe_in_valid) begin
        issue_cnt <= issue_cnt + 1;
        last_psum <= pe_psum;
        if (pe_pending) overlap <= 1'b1;
        if (!pe_hang) begin
          if (pe_lat <= 1) begin
            pe_out_valid <= 1'b1;
            pe_psum_out  <= pe_fn(pe_a, pe_b, pe_psum);
          end else begin
            pe_pending <= 1'b1;
            pe_left    <= pe_lat - 1;
            pe_res     <= pe_fn(pe_a, pe_b, pe_psum);
          end
        end
      end else if (pe_pending) begin
        if (pe_left <= 1) begin
          pe_out_valid <= 1'b1;
          pe_psum_out  <= pe_res;
          pe_pending   <= 1'b0;
        end else begin
          pe_left <= pe_left - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_op(input int idx, input bit gaps);
    op_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    op_a = (idx < 64) ? int_to_fp(opa_tab[idx]) : 32'h0;
    op_b = (idx < 64) ? int_to_fp(opb_tab[idx]) : 32'h0;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (!pe_in_valid && n < 50) begin
      tick();
      start = 1'b0;
      n++;
    end
    check({name, " issue seen"}, 32'(pe_in_valid), 32'd1);
  endtask

  // Runs one job from start to done; operands come from opa_tab/opb_tab.
  task automatic run_job(input logic [6:0] jl, input int unsigned ji, input int lat, input bit gaps,
                         input int hold, input logic [31:0] exp_res, input int exp_lat, input string tag);
    int n_terms, idx, cycles, base;
    bit hs;
    n_terms   = (jl > 7'd64) ? 64 : int'(jl);
    base      = issue_cnt;
    pe_lat    = lat;
    start     = 1'b1;
    len       = jl;
    init_psum = int_to_fp(ji);
    idx       = 0;
    cycles    = 0;
    drive_op(idx, gaps);
    do begin
      hs = op_valid && op_ready;
      tick();
      cycles++;
      start = 1'b0;
      if (hs) idx++;
      drive_op(idx, gaps);
    end while (!res_valid && cycles < 3000);
    op_valid = 1'b0;
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    if (!res_valid) return;
    check({tag, " res_data"}, res_data, exp_res);
    check({tag, " terms consumed"}, 32'(idx), 32'(n_terms));
    check({tag, " pe issues"}, 32'(issue_cnt - base), 32'(n_terms));
    if (!gaps) check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, " held result"}, {res_valid, res_data[30:0]}, {1'b1, exp_res[30:0]});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " done pulse"}, {done, res_valid}, 32'b10);
    tick();
    check({tag, " done width"}, {done, busy}, 32'b00);
  endtask

  typedef struct {
    logic [6:0]  len;
    int unsigned init;
    int          lat;
    bit          plan;
    logic [31:0] exp_res;
    logic [31:0] exp_psum;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, n;
    bit saw_res, saw_done, bad;
    int unsigned ji, sum;
    logic [6:0] jl;

    vecs[0] = '{7'd2,   0,  7, 1'b1, 32'h41300000, 32'h40400000, 19};
    vecs[1] = '{7'd1,   5,  1, 1'b0, 32'h40E00000, 32'h40A00000, 4};
    vecs[2] = '{7'd3,   0,  3, 1'b0, 32'h41400000, 32'h40C00000, 16};
    vecs[3] = '{7'd0,   1,  4, 1'b0, 32'h3F800000, 32'h00000000, 1};
    vecs[4] = '{7'd4,   10, 5, 1'b0, 32'h41F00000, 32'h41B00000, 29};
    vecs[5] = '{7'd64,  0,  2, 1'b0, 32'h45820000, 32'h457C0000, 257};
    vecs[6] = '{7'd100, 0,  1, 1'b0, 32'h45820000, 32'h457C0000, 193};

    rst = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    len = '0; init_psum = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ctrl", {busy, done, err, pe_in_valid, res_valid, op_ready}, 32'd0);
    check("reset data", pe_a | pe_b | pe_psum | res_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table-driven jobs with op_valid held high
    for (int i = 0; i < 7; i++) begin
      for (int t = 0; t < 64; t++) begin
        opa_tab[t] = vecs[i].plan ? (t == 0 ? 1 : 2) : 2;
        opb_tab[t] = vecs[i].plan ? (t == 0 ? 3 : 4) : t + 1;
      end
      run_job(vecs[i].len, vecs[i].init, vecs[i].lat, 1'b0, (i == 0) ? 2 : 0,
              vecs[i].exp_res, vecs[i].exp_lat, $sformatf("vec%0d", i));
      if (vecs[i].len != 0) check($sformatf("vec%0d last psum", i), last_psum, vecs[i].exp_psum);
    end

    // Result back-pressure, start while busy ignored, start on the done cycle accepted
    pe_lat = 3; base = issue_cnt;
    start = 1'b1; len = 7'd1; init_psum = int_to_fp(20);
    op_valid = 1'b1; op_a = int_to_fp(3); op_b = int_to_fp(4);
    tick();
    len = 7'd5;
    repeat (3) tick();
    start = 1'b0;
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    op_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("bp hold", {res_valid, res_data[30:0]}, {1'b1, 31'h42000000});
      if (k < 5) tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp done", {done, res_valid}, 32'b10);
    start = 1'b1; len = 7'd0; init_psum = int_to_fp(9);
    tick();
    start = 1'b0;
    check("done-cycle start", {res_valid, done, res_data[30:0]}, {2'b10, 31'h41100000});
    check("busy start ignored", 32'(issue_cnt - base), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();

    // Watchdog: PE never answers
    pe_hang = 1'b1;
    for (int t = 0; t < 64; t++) begin opa_tab[t] = 2; opb_tab[t] = t + 1; end
    start = 1'b1; len = 7'd3; init_psum = int_to_fp(7); drive_op(0, 1'b0);
    wait_issue("timeout");
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    check("timeout cycles", 32'(n), 32'd16);
    check("timeout partial", {res_valid, res_data[30:0]}, {1'b1, 31'h40E00000});
    op_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("timeout done, err sticky", {done, err}, 32'b11);
    pe_hang = 1'b0;
    tick();
    start = 1'b1; len = 7'd0; init_psum = 32'h0;
    tick();
    start = 1'b0;
    check("err cleared by start", 32'(err), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();

    // Abort in WAIT drains the outstanding op
    pe_lat = 7;
    start = 1'b1; len = 7'd3; init_psum = int_to_fp(4); drive_op(0, 1'b0);
    wait_issue("abort");
    n = 0;
    repeat (2) begin tick(); n++; end
    abort = 1'b1; op_valid = 1'b0;
    tick(); n++;
    abort = 1'b0;
    check("drain busy", {busy, op_ready}, 32'b10);
    saw_res = 1'b0; saw_done = 1'b0;
    while (busy && n < 40) begin
      saw_res  |= res_valid;
      saw_done |= done;
      tick(); n++;
    end
    check("drain length", 32'(n), 32'd8);
    tick();
    check("drain no result", {saw_res, saw_done, done}, 32'd0);
    run_job(7'd2, 0, 3, 1'b0, 0, 32'h40C00000, 11, "post-abort");

    // Abort in FETCH and in RESULT
    base = issue_cnt;
    start = 1'b1; len = 7'd2; init_psum = 32'h0; op_valid = 1'b0;
    tick();
    start = 1'b0; abort = 1'b1; op_valid = 1'b1;
    tick();
    abort = 1'b0; op_valid = 1'b0;
    check("fetch abort idle", 32'(busy), 32'd0);
    tick();
    check("fetch abort no issue", 32'(issue_cnt - base), 32'd0);
    start = 1'b1; len = 7'd0;
    tick();
    start = 1'b0; abort = 1'b1; res_ready = 1'b1;
    tick();
    abort = 1'b0; res_ready = 1'b0;
    check("result abort", {busy, res_valid, done}, 32'd0);

    // Asynchronous reset mid-FETCH and mid-WAIT
    start = 1'b1; len = 7'd3; init_psum = int_to_fp(2); op_valid = 1'b0;
    tick();
    start = 1'b0;
    check("fetch before reset", 32'(op_ready), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst fetch ctrl", {busy, done, err, pe_in_valid, res_valid, op_ready}, 32'd0);
    check("rst fetch data", pe_a | pe_b | pe_psum | res_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    pe_lat = 7;
    start = 1'b1; len = 7'd3; init_psum = int_to_fp(2); drive_op(0, 1'b0);
    wait_issue("rst wait");
    #2 rst = 1'b0;
    #1;
    check("rst wait ctrl", {busy, pe_in_valid, op_ready, res_valid}, 32'd0);
    check("rst wait data", pe_a | pe_b | pe_psum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    op_valid = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      tick();
      bad |= op_ready | busy;
    end
    op_valid = 1'b0;
    check("no op_ready without start", 32'(bad), 32'd0);
    run_job(7'd1, 0, 2, 1'b0, 0, 32'h40000000, 5, "post-reset");

    // Randomized jobs against an integer dot-product reference
    for (int j = 0; j < 20; j++) begin
      jl = 7'($urandom_range(1, 12));
      ji = $urandom_range(0, 1000);
      sum = ji;
      for (int t = 0; t < 64; t++) begin
        opa_tab[t] = $urandom_range(0, 15);
        opb_tab[t] = $urandom_range(0, 15);
        if (t < int'(jl)) sum += opa_tab[t] * opb_tab[t];
      end
      run_job(jl, ji, $urandom_range(1, 10), 1'b1, $urandom_range(0, 3),
              int_to_fp(sum), 0, $sformatf("rnd%0d", j));
    end

    check("single outstanding", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global time limit: got no finish, expected finish");
    $fatal(1);
  end

endmodule
